// File: rtl/led_pkg.sv
// Shared types and timing defaults for the LED flasher and its helpers.
package led_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ON,
    GAP
  } flash_state_t;

  localparam int DEF_ON_CYCLES  = 250;
  localparam int DEF_GAP_CYCLES = 250;

  // Width of the shared ON/GAP down-counter; never allowed to collapse to zero bits.
  function automatic int cnt_width(input int on_cycles, input int gap_cycles);
    int longest;
    longest = (on_cycles > gap_cycles) ? on_cycles : gap_cycles;
    return ($clog2(longest) < 1) ? 1 : $clog2(longest);
  endfunction

endpackage

// File: rtl/sat_updown_cnt.sv
// Saturating up/down counter used to hold events waiting for a flash slot.
module sat_updown_cnt #(
  parameter int W = 3
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] count_o,
  output logic         full_o
);

  localparam logic [W-1:0] MAX = '1;

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Simultaneous inc and dec cancel; otherwise clamp at both ends.
  always_comb begin
    count_d = count_q;
    if (inc_i && !dec_i && (count_q != MAX)) begin
      count_d = count_q + 1'b1;
    end else if (dec_i && !inc_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign full_o  = (count_q == MAX);

endmodule

// File: rtl/led_flasher.sv
// Turns single-cycle event pulses into fixed-length LED flashes separated by a
// mandatory dark gap, queueing events that arrive while a flash is running.
module led_flasher
  import led_pkg::*;
#(
  parameter int ON_CYCLES  = DEF_ON_CYCLES,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int PEND_W     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              evt_in,
  output logic              led_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  localparam int CW = cnt_width(ON_CYCLES, GAP_CYCLES);
  localparam logic [CW-1:0] ON_LOAD  = CW'(ON_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYCLES - 1);

  flash_state_t state_q;
  logic [CW-1:0] cnt_q;
  logic          led_q;
  logic          busy_q;
  logic          ovf_q;

  logic cnt_zero;
  logic gap_end;
  logic have_pend;
  logic pend_full;
  logic direct_start;
  logic evt_inc;
  logic evt_dec;
  logic evt_drop;

  // A queued event always wins the slot at the end of a gap; a fresh event
  // only starts directly when nothing is waiting.
  assign cnt_zero     = (cnt_q == '0);
  assign gap_end      = (state_q == GAP) && cnt_zero;
  assign have_pend    = (pending != '0);
  assign evt_dec      = gap_end && have_pend;
  assign direct_start = gap_end && !have_pend && evt_in;
  assign evt_inc      = evt_in && (state_q != IDLE) && !direct_start;
  assign evt_drop     = evt_inc && pend_full && !evt_dec;

  sat_updown_cnt #(
    .W(PEND_W)
  ) u_pend (
    .clk_i  (clk),
    .rst_i  (rst),
    .inc_i  (evt_inc),
    .dec_i  (evt_dec),
    .count_o(pending),
    .full_o (pend_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      ovf_q <= evt_drop;
      unique case (state_q)
        IDLE: begin
          if (evt_in) begin
            state_q <= ON;
            cnt_q   <= ON_LOAD;
            led_q   <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        ON: begin
          if (!cnt_zero) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            state_q <= GAP;
            cnt_q   <= GAP_LOAD;
            led_q   <= 1'b0;
          end
        end
        GAP: begin
          if (!cnt_zero) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (have_pend || evt_in) begin
            state_q <= ON;
            cnt_q   <= ON_LOAD;
            led_q   <= 1'b1;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          led_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign led_out  = led_q;
  assign busy     = busy_q;
  assign overflow = ovf_q;

endmodule

// File: doc/led_flasher.md
# led_flasher

Output-side companion to the button debouncer: it turns clean single-cycle event pulses into human-visible LED flashes. Each accepted event produces one flash of fixed on-time, followed by a mandatory dark gap. Events arriving while a flash is in progress are queued in a saturating pending counter. The block sits between the game/control logic and an LED pin.

## Interface
- ON_CYCLES, 250: LED high time per flash, in clk cycles; must be ≥1.
- GAP_CYCLES, 250: minimum LED low time after each flash, in clk cycles; must be ≥1.
- PEND_W, 3: width of the pending-event counter; the queue holds at most 2^PEND_W−1 events.

Ports:
- clk  in  1  system clock; one clock domain, all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- evt_in  in  1  event request; each cycle it is high counts as one event.
- led_out  out  1  LED drive, registered.
- busy  out  1  high whenever the state is not IDLE.
- pending  out  PEND_W  events accepted but not yet started.
- overflow  out  1  one-cycle pulse when an event is dropped.

## Operation
- FSM states: IDLE, ON, GAP. A single down-counter `cnt` is shared by ON and GAP; its width is $clog2(max(ON_CYCLES,GAP_CYCLES)).
- IDLE:
  - evt_in=1 → go to ON, load cnt=ON_CYCLES−1.
  - pending is not incremented in this case.
- ON:
  - led_out=1.
  - cnt≠0 → decrement cnt.
  - cnt=0 → go to GAP, load cnt=GAP_CYCLES−1.
- GAP:
  - led_out=0.
  - cnt≠0 → decrement cnt.
  - cnt=0 and (pending>0 or evt_in=1) → go to ON, load cnt=ON_CYCLES−1, consume one event.
  - cnt=0 otherwise → go to IDLE.
- Event consumption at the end of GAP:
  - A queued event is consumed first.
  - If pending=0, a same-cycle evt_in starts the flash directly without touching pending.
- Pending update, per cycle, given inc = evt_in accepted into the queue and dec = queued event consumed:
  - inc without dec → +1.
  - dec without inc → −1.
  - inc and dec together → unchanged.
- An evt_in is queued (inc) when:
  - the state is ON or GAP, and
  - it is not being used for a direct start at the end of GAP.
- Overflow:
  - Condition: an event would be queued, pending equals 2^PEND_W−1, and no dec occurs in the same cycle.
  - Result: the event is dropped, pending stays at max, and overflow=1 for exactly that following cycle.
- led_out equals (state==ON) and is taken from the state register; it has no combinational path from evt_in.

## Timing
- Reset values: state=IDLE, cnt=0, pending=0, led_out=0, busy=0, overflow=0.
- Reset applies at the next rising edge and overrides everything. A reset during ON or GAP aborts the flash and clears the queue.
- Latency: evt_in high in cycle N while IDLE → led_out high from cycle N+1 through N+ON_CYCLES.
- After the flash, led_out is low for exactly GAP_CYCLES cycles.
- Back-to-back flashes: period is exactly ON_CYCLES+GAP_CYCLES. led_out rises again on the cycle after the last GAP cycle.
- busy goes high in cycle N+1 and falls on the cycle after the final GAP cycle, when no event is waiting.
- pending and overflow are registered and update one cycle after the evt_in that caused them.

## Structure
- Shared package `led_pkg`:
  - state enum `flash_state_t` {IDLE, ON, GAP};
  - default timing constants DEF_ON_CYCLES and DEF_GAP_CYCLES.
- One sub-module, `sat_updown_cnt`: saturating up/down counter, parameter W, inputs inc/dec, outputs count and a full flag. It implements pending and flags the overflow condition.
- Top level holds the FSM and the timing down-counter.

## Test plan
Common parameters for all scenarios: ON=4, GAP=3, PEND_W=2.
- Single event: evt_in pulse at cycle 10.
  - led_out high in cycles 11–14, low in 15–17.
  - busy high in 11–17, low from 18.
  - pending stays 0.
- Queued burst: evt_in at cycles 10, 12, 13.
  - pending reads 1 after 12 and 2 after 13.
  - Three flashes start at cycles 11, 18 and 25; busy falls at cycle 32.
- Overflow: evt_in held high in cycles 10–15.
  - pending saturates at 3.
  - overflow pulses 1 cycle for each dropped event (2 pulses).
  - Exactly 4 flashes are produced.
- Coincident events: evt_in in the last GAP cycle (17) with pending=0 → led_out high in 18–21, no gap extension, pending stays 0.
  - Same cycle with pending=1 → pending stays 1.
- Reset mid-flash: rst high at cycle 13 during ON with pending=2 → at cycle 14 led_out=0, busy=0, pending=0.
  - No flash occurs afterward without a new evt_in.
